// File: rtl/spi_master_if.sv
// spi_master_if: control, data and SPI pin bundle for spi_master; crc_tx_out exists only with SPI_MASTER_CRC_EN.
interface spi_master_if #(parameter int DIV_W = 8);
  logic             ena;
  logic [DIV_W-1:0] div;
  logic             start;
  logic [7:0]       bus_in;
  logic [7:0]       bus_out;
  logic             tx;
  logic             rx;
  logic             busy;
  logic             spi_clk;
  logic             spi_ss;
  logic             spi_out;
  logic             spi_in;
`ifdef SPI_MASTER_CRC_EN
  logic [7:0]       crc_tx_out;
`endif
  modport master (
    input  ena, div, start, bus_in, spi_in,
    output bus_out, tx, rx, busy, spi_clk, spi_ss, spi_out
`ifdef SPI_MASTER_CRC_EN
    , output crc_tx_out
`endif
  );
  modport slave (
    output ena, div, start, bus_in, spi_in,
    input  bus_out, tx, rx, busy, spi_clk, spi_ss, spi_out
`ifdef SPI_MASTER_CRC_EN
    , input crc_tx_out
`endif
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: CPOL=0 byte-wide SPI master, MOSI launched on rising SCK, MISO sampled on falling SCK.
// Optional SPI_MASTER_CRC_EN adds a CRC-8 (poly 0x07) over transmitted bits.
module spi_master #(
  parameter int DIV_W = 8
) (
  input logic         clk,
  input logic         rst,
  spi_master_if.master spi_io
);
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_e;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bits_q, bits_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       bus_out_q, bus_out_d;
  logic             rx_pend_q, rx_pend_d;
  logic             tx_q, tx_d;
  logic             rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bus_out_q <= '0;
      rx_pend_q <= 1'b0;
      tx_q      <= 1'b0;
      rx_q      <= 1'b0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bus_out_q <= bus_out_d;
      rx_pend_q <= rx_pend_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
    end
  end
  // tx/rx pulses clear every clk so they stay one cycle wide even while ena is low
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    bus_out_d = bus_out_q;
    rx_pend_d = rx_pend_q;
    tx_d      = 1'b0;
    rx_d      = 1'b0;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    if (spi_io.ena) begin
      if (rx_pend_q) begin
        rx_d      = 1'b1;
        bus_out_d = rx_sh_q;
        rx_pend_d = 1'b0;
      end
      if (state_q == IDLE) begin
        if (spi_io.start) begin
          tx_sh_d = spi_io.bus_in;
          tx_d    = 1'b1;
          bits_d  = '0;
          cnt_d   = spi_io.div;
          ss_d    = 1'b0;
          state_d = LEAD;
        end
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_W'(1);
      end else begin
        cnt_d = spi_io.div;
        case (state_q)
          LEAD: begin
            state_d = HIGH;
            sclk_d  = 1'b1;
            mosi_d  = tx_sh_q[7];
          end
          HIGH: begin
            state_d   = LOW;
            sclk_d    = 1'b0;
            rx_sh_d   = {rx_sh_q[6:0], spi_io.spi_in};
            bits_d    = bits_q + 4'd1;
            rx_pend_d = (bits_q == 4'd7);
          end
          LOW: begin
            if (bits_q != 4'd8) begin
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              mosi_d  = tx_sh_q[6];
              sclk_d  = 1'b1;
              state_d = HIGH;
            end else if (spi_io.start) begin
              tx_sh_d = spi_io.bus_in;
              tx_d    = 1'b1;
              bits_d  = '0;
              mosi_d  = spi_io.bus_in[7];
              sclk_d  = 1'b1;
              state_d = HIGH;
            end else begin
              state_d = TRAIL;
            end
          end
          TRAIL: begin
            state_d = IDLE;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef SPI_MASTER_CRC_EN
  logic [7:0] crc_q, crc_d;
  always_ff @(posedge clk) crc_q <= rst ? 8'h00 : crc_d;
  // one CRC step per rising SCK edge, using the bit launched on that edge
  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE && state_d == LEAD)
      crc_d = 8'h00;
    else if (state_d == HIGH && state_q != HIGH)
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ mosi_d) ? 8'h07 : 8'h00);
  end
  assign spi_io.crc_tx_out = crc_q;
`endif
  assign spi_io.bus_out = bus_out_q;
  assign spi_io.tx      = tx_q;
  assign spi_io.rx      = rx_q;
  assign spi_io.busy    = state_q != IDLE;
  assign spi_io.spi_clk = sclk_q;
  assign spi_io.spi_ss  = ss_q;
  assign spi_io.spi_out = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scenario tasks for spi_master with a pin monitor and a received-byte scoreboard.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b1;
  logic miso_v = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0, tx_cnt = 0, rx_cnt = 0, ss_falls = 0, ss_fall_cyc = 0, ss_low = 0;
  int rises = 0, falls = 0, edges = 0, last_edge = 0, lead = 0;
  logic [31:0] mosi_sr = '0;
  logic prev_ss = 1'b1, prev_clk = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ph_q[$];

  spi_master_if #(.DIV_W(8)) sif();
  spi_master #(.DIV_W(8)) dut (.clk(clk), .rst(rst), .spi_io(sif));

  assign sif.spi_in = loop ? sif.spi_out : miso_v;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (sif.tx) tx_cnt++;
    if (sif.rx) begin
      rx_cnt++;
      got_q.push_back(sif.bus_out);
    end
    if (!sif.spi_ss) ss_low++;
    if (prev_ss && !sif.spi_ss) begin
      ss_falls++;
      ss_fall_cyc = cyc;
    end
    if (sif.spi_clk != prev_clk) begin
      if (edges > 0) ph_q.push_back(cyc - last_edge);
      if (sif.spi_clk) begin
        if (rises == 0) lead = cyc - ss_fall_cyc;
        rises++;
        mosi_sr = {mosi_sr[30:0], sif.spi_out};
      end else falls++;
      edges++;
      last_edge = cyc;
    end
    prev_ss = sif.spi_ss;
    prev_clk = sif.spi_clk;
  end

  task clear_mon;
    tx_cnt = 0; rx_cnt = 0; ss_falls = 0; ss_low = 0; rises = 0; falls = 0;
    edges = 0; lead = 0; mosi_sr = '0;
    exp_q.delete(); got_q.delete(); ph_q.delete();
  endtask

  task send(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    sif.bus_in = b;
    sif.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.tx) begin ok = 1'b1; break; end
    end
    sif.start = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (!sif.busy) begin ok = 1'b1; break; end
      end
    end
  endtask

  task test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sif.spi_ss !== 1'b1) begin errors++; $display("FAIL rst_ss got %b exp 1", sif.spi_ss); end
    checks++; if (sif.spi_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", sif.spi_clk); end
    checks++; if (sif.spi_out !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", sif.spi_out); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", sif.busy); end
    checks++; if (sif.tx !== 1'b0 || sif.rx !== 1'b0) begin errors++; $display("FAIL rst_pulses got tx=%b rx=%b exp 0 0", sif.tx, sif.rx); end
    checks++; if (sif.bus_out !== 8'h00) begin errors++; $display("FAIL rst_bus_out got %h exp 00", sif.bus_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task test_basic;
    bit ok;
    int bad;
    sif.div = 8'd0; loop = 1'b1;
    clear_mon();
    exp_q.push_back(8'hA5);
    send(8'hA5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no completion exp completion"); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL basic_rises got %0d exp 8", rises); end
    checks++; if (mosi_sr[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_mosi got %h exp a5", mosi_sr[7:0]); end
    checks++; if (tx_cnt !== 1 || rx_cnt !== 1) begin errors++; $display("FAIL basic_pulses got tx=%0d rx=%0d exp 1 1", tx_cnt, rx_cnt); end
    checks++; if (ss_falls !== 1 || ss_low !== 18) begin errors++; $display("FAIL basic_ss got falls=%0d low=%0d exp 1 18", ss_falls, ss_low); end
    bad = 0;
    foreach (ph_q[i]) if (ph_q[i] != 1) bad++;
    checks++; if (bad != 0 || ph_q.size() != 15) begin errors++; $display("FAIL basic_phases got bad=%0d n=%0d exp 0 15", bad, ph_q.size()); end
    checks++; if (sif.spi_ss !== 1'b1 || sif.spi_out !== 1'b0) begin errors++; $display("FAIL basic_idle got ss=%b mosi=%b exp 1 0", sif.spi_ss, sif.spi_out); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_rx_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_rx_data got %h exp %h", g, e); end
    end
  endtask

  task test_div3;
    bit ok;
    int bad;
    sif.div = 8'd3; loop = 1'b1;
    clear_mon();
    exp_q.push_back(8'h5A);
    send(8'h5A, ok);
    checks++; if (!ok) begin errors++; $display("FAIL div3_timeout got no completion exp completion"); end
    bad = 0;
    foreach (ph_q[i]) if (ph_q[i] != 4) bad++;
    checks++; if (bad != 0 || ph_q.size() != 15) begin errors++; $display("FAIL div3_phases got bad=%0d n=%0d exp 0 15", bad, ph_q.size()); end
    checks++; if (lead !== 4) begin errors++; $display("FAIL div3_lead got %0d exp 4", lead); end
    checks++; if (ss_low !== 72) begin errors++; $display("FAIL div3_ss_low got %0d exp 72", ss_low); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL div3_rx_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL div3_rx_data got %h exp %h", g, e); end
    end
    sif.div = 8'd0;
  endtask

  task test_back_to_back;
    bit ok1, ok2, ok3;
    int bad;
    sif.div = 8'd0; loop = 1'b0; miso_v = 1'b1;
    clear_mon();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    ok1 = 1'b0; ok2 = 1'b0; ok3 = 1'b0;
    sif.bus_in = 8'h3C; sif.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.tx) begin ok1 = 1'b1; break; end
    end
    sif.bus_in = 8'hC3;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.tx) begin ok2 = 1'b1; break; end
    end
    sif.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!sif.busy) begin ok3 = 1'b1; break; end
    end
    checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL b2b_timeout got %b%b%b exp 111", ok1, ok2, ok3); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL b2b_rises got %0d exp 16", rises); end
    checks++; if (mosi_sr[15:0] !== 16'h3CC3) begin errors++; $display("FAIL b2b_mosi got %h exp 3cc3", mosi_sr[15:0]); end
    checks++; if (tx_cnt !== 2) begin errors++; $display("FAIL b2b_tx got %0d exp 2", tx_cnt); end
    checks++; if (ss_falls !== 1 || ss_low !== 34) begin errors++; $display("FAIL b2b_ss got falls=%0d low=%0d exp 1 34", ss_falls, ss_low); end
    bad = 0;
    foreach (ph_q[i]) if (ph_q[i] != 1) bad++;
    checks++; if (bad != 0 || ph_q.size() != 31) begin errors++; $display("FAIL b2b_phases got bad=%0d n=%0d exp 0 31", bad, ph_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_rx_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_rx_data got %h exp %h", g, e); end
    end
    loop = 1'b1;
  endtask

  task test_reset_mid;
    bit ok;
    sif.div = 8'd1; loop = 1'b1;
    clear_mon();
    ok = 1'b0;
    sif.bus_in = 8'h96; sif.start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.tx) break;
    end
    sif.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (falls >= 4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got falls=%0d exp 4", falls); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sif.spi_ss !== 1'b1 || sif.spi_clk !== 1'b0) begin errors++; $display("FAIL midrst_pins got ss=%b sclk=%b exp 1 0", sif.spi_ss, sif.spi_clk); end
    checks++; if (sif.bus_out !== 8'h00) begin errors++; $display("FAIL midrst_bus_out got %h exp 00", sif.bus_out); end
    checks++; if (sif.busy !== 1'b0 || sif.spi_out !== 1'b0) begin errors++; $display("FAIL midrst_busy got busy=%b mosi=%b exp 0 0", sif.busy, sif.spi_out); end
    rst = 1'b0;
    rx_cnt = 0;
    repeat (60) @(negedge clk);
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL midrst_rx got %0d exp 0", rx_cnt); end
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b exp 0", sif.busy); end
    sif.div = 8'd0;
  endtask

  task test_ena_toggle;
    bit ok, seen;
    int bad;
    sif.div = 8'd0; loop = 1'b1;
    clear_mon();
    exp_q.push_back(8'hA5);
    ok = 1'b0; seen = 1'b0;
    sif.bus_in = 8'hA5; sif.start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sif.ena = ~sif.ena;
      if (sif.tx) begin seen = 1'b1; sif.start = 1'b0; end
      if (seen && !sif.busy) begin ok = 1'b1; break; end
    end
    sif.ena = 1'b1;
    sif.start = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ena_timeout got no completion exp completion"); end
    checks++; if (rises !== 8 || mosi_sr[7:0] !== 8'hA5) begin errors++; $display("FAIL ena_mosi got n=%0d %h exp 8 a5", rises, mosi_sr[7:0]); end
    checks++; if (tx_cnt !== 1 || rx_cnt !== 1) begin errors++; $display("FAIL ena_pulses got tx=%0d rx=%0d exp 1 1", tx_cnt, rx_cnt); end
    bad = 0;
    foreach (ph_q[i]) if (ph_q[i] != 2) bad++;
    checks++; if (bad != 0 || ph_q.size() != 15) begin errors++; $display("FAIL ena_phases got bad=%0d n=%0d exp 0 15", bad, ph_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ena_rx_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL ena_rx_data got %h exp %h", g, e); end
    end
  endtask

`ifdef SPI_MASTER_CRC_EN
  task test_crc;
    bit ok;
    sif.div = 8'd0; loop = 1'b1;
    send(8'h01, ok);
    checks++; if (!ok || sif.crc_tx_out !== 8'h07) begin errors++; $display("FAIL crc_01 got %h exp 07", sif.crc_tx_out); end
    send(8'h00, ok);
    checks++; if (!ok || sif.crc_tx_out !== 8'h00) begin errors++; $display("FAIL crc_00 got %h exp 00", sif.crc_tx_out); end
  endtask
`endif

  initial begin
    sif.ena = 1'b1;
    sif.div = 8'd0;
    sif.start = 1'b0;
    sif.bus_in = 8'h00;
    test_reset();
    test_basic();
    test_div3();
    test_back_to_back();
    test_reset_mid();
    test_ena_toggle();
`ifdef SPI_MASTER_CRC_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
